// File: rtl/crc_job_sched_if.sv
// Requester job/data channels plus the CRC register bus of crc_job_sched.
// master = scheduler side, slave = requesters and CRC peripheral side.
interface crc_job_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*32-1:0]    req_ctrl;
  logic [NREQ*32-1:0]    req_poly;
  logic [NREQ*32-1:0]    req_seed;
  logic [NREQ*CNT_W-1:0] req_len;
  logic [NREQ-1:0]       dat_valid;
  logic [NREQ*32-1:0]    dat_word;
  logic [NREQ-1:0]       dat_ready;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [31:0]           result;
  logic                  err;
  logic                  sel;
  logic                  rw;
  logic [31:0]           addr;
  logic [31:0]           data_wr;
  logic [31:0]           data_rd;

  modport master (
    input  req, req_ctrl, req_poly, req_seed, req_len, dat_valid, dat_word, data_rd,
    output dat_ready, gnt, done, result, err, sel, rw, addr, data_wr
  );

  modport slave (
    output req, req_ctrl, req_poly, req_seed, req_len, dat_valid, dat_word, data_rd,
    input  dat_ready, gnt, done, result, err, sel, rw, addr, data_wr
  );
endinterface

// File: rtl/crc_job_sched.sv
// Round-robin scheduler sharing one CRC peripheral between NREQ requesters.
// Optional data-stall timeout enabled by defining CRC_SCHED_TIMEOUT_EN.
module crc_job_sched #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned CNT_W     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h4003_2000
) (
  input  logic           clk,
  input  logic           rst_n,
  crc_job_sched_if.master bus
);
  localparam int unsigned IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0] ADDR_DATA = BASE_ADDR;
  localparam logic [31:0] ADDR_POLY = BASE_ADDR + 32'd4;
  localparam logic [31:0] ADDR_CTRL = BASE_ADDR + 32'd8;
  localparam logic [31:0] WAS_BIT   = 32'h0200_0000;
`ifdef CRC_SCHED_TIMEOUT_EN
  localparam int unsigned STALL_W     = 16;
  localparam logic [15:0] STALL_LIMIT = 16'd999;
`endif

  typedef enum logic [2:0] {
    IDLE, CFG_CTRL, CFG_POLY, CFG_SEED, CFG_RUN, DATA, READ, FIN
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_q, rr_d, gidx_q, gidx_d;
  logic [31:0]         ctrl_q, ctrl_d, poly_q, poly_d, seed_q, seed_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]     gnt_q, gnt_d, done_q, done_d;
  logic [31:0]         result_q, result_d;
  logic                err_q, err_d;
`ifdef CRC_SCHED_TIMEOUT_EN
  logic [STALL_W-1:0]  stall_q, stall_d;
`endif

  logic                win_found_c;
  logic [IDX_W-1:0]    win_idx_c;
  logic [31:0]         word_c;
  logic                word_vld_c;
  logic                sel_c, rw_c;
  logic [31:0]         addr_c, data_wr_c;
  logic [NREQ-1:0]     dat_ready_c;

  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
    return IDX_W'(v % NREQ);
  endfunction

  // First pending requester at or after the round-robin pointer.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!win_found_c && bus.req[wrap_idx(32'(rr_q) + k)]) begin
        win_found_c = 1'b1;
        win_idx_c   = wrap_idx(32'(rr_q) + k);
      end
    end
  end

  assign word_c     = bus.dat_word[32'(gidx_q)*32 +: 32];
  assign word_vld_c = bus.dat_valid[gidx_q];

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gidx_d      = gidx_q;
    ctrl_d      = ctrl_q;
    poly_d      = poly_q;
    seed_d      = seed_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    result_d    = result_q;
    err_d       = err_q;
`ifdef CRC_SCHED_TIMEOUT_EN
    stall_d     = stall_q;
`endif
    sel_c       = 1'b0;
    rw_c        = 1'b0;
    addr_c      = '0;
    data_wr_c   = '0;
    dat_ready_c = '0;

    case (state_q)
      IDLE: begin
        if (win_found_c) begin
          gidx_d  = win_idx_c;
          ctrl_d  = bus.req_ctrl[32'(win_idx_c)*32 +: 32];
          poly_d  = bus.req_poly[32'(win_idx_c)*32 +: 32];
          seed_d  = bus.req_seed[32'(win_idx_c)*32 +: 32];
          cnt_d   = bus.req_len[32'(win_idx_c)*CNT_W +: CNT_W];
          gnt_d   = NREQ'(1) << win_idx_c;
          rr_d    = wrap_idx(32'(win_idx_c) + 32'd1);
          state_d = CFG_CTRL;
        end
      end
      CFG_CTRL: begin
        sel_c     = 1'b1;
        rw_c      = 1'b1;
        addr_c    = ADDR_CTRL;
        data_wr_c = ctrl_q | WAS_BIT;
        state_d   = CFG_POLY;
      end
      CFG_POLY: begin
        sel_c     = 1'b1;
        rw_c      = 1'b1;
        addr_c    = ADDR_POLY;
        data_wr_c = poly_q;
        state_d   = CFG_SEED;
      end
      CFG_SEED: begin
        sel_c     = 1'b1;
        rw_c      = 1'b1;
        addr_c    = ADDR_DATA;
        data_wr_c = seed_q;
        state_d   = CFG_RUN;
      end
      CFG_RUN: begin
        sel_c     = 1'b1;
        rw_c      = 1'b1;
        addr_c    = ADDR_CTRL;
        data_wr_c = ctrl_q & ~WAS_BIT;
        state_d   = (cnt_q != '0) ? DATA : READ;
`ifdef CRC_SCHED_TIMEOUT_EN
        stall_d   = '0;
`endif
      end
      DATA: begin
        dat_ready_c = gnt_q;
        if (word_vld_c) begin
          sel_c     = 1'b1;
          rw_c      = 1'b1;
          addr_c    = ADDR_DATA;
          data_wr_c = word_c;
          cnt_d     = cnt_q - CNT_W'(1);
`ifdef CRC_SCHED_TIMEOUT_EN
          stall_d   = '0;
`endif
          if (cnt_q == CNT_W'(1)) state_d = READ;
        end
`ifdef CRC_SCHED_TIMEOUT_EN
        // Starved job: finish with an error instead of reading the CRC.
        else if (stall_q == STALL_LIMIT) begin
          done_d   = gnt_q;
          err_d    = 1'b1;
          result_d = '0;
          state_d  = FIN;
        end else begin
          stall_d  = stall_q + STALL_W'(1);
        end
`endif
      end
      READ: begin
        sel_c    = 1'b1;
        addr_c   = ADDR_DATA;
        result_d = bus.data_rd;
        err_d    = 1'b0;
        done_d   = gnt_q;
        state_d  = FIN;
      end
      FIN: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      gidx_q   <= '0;
      ctrl_q   <= '0;
      poly_q   <= '0;
      seed_q   <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
`ifdef CRC_SCHED_TIMEOUT_EN
      stall_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gidx_q   <= gidx_d;
      ctrl_q   <= ctrl_d;
      poly_q   <= poly_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
`ifdef CRC_SCHED_TIMEOUT_EN
      stall_q  <= stall_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
  assign bus.sel       = sel_c;
  assign bus.rw        = rw_c;
  assign bus.addr      = addr_c;
  assign bus.data_wr   = data_wr_c;
  assign bus.dat_ready = dat_ready_c;
endmodule

// File: doc/crc_job_sched.md
Name: crc_job_sched

Overview:
- Round-robin scheduler that shares the single CRC peripheral between NREQ requesters.
- Each requester submits a job: control word, polynomial, seed, word count and a data stream. The scheduler grants one job at a time.
- For the granted job it drives the CRC register bus:
  - configure (CTRL with WAS=1, GPOLY, seed),
  - switch to data mode,
  - stream data words,
  - read the checksum back.
- It then returns the result with a one-cycle done pulse.

Parameters:
NREQ, 4, number of requesters (2..8)
CNT_W, 8, width of job word count
BASE_ADDR, 32'h4003_2000, CRC data/seed register address; GPOLY = BASE+4, CTRL = BASE+8

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  job request, one bit per requester
req_ctrl  in  NREQ*32  CRC_CTRL value per requester (slice i = bits 32i+31:32i)
req_poly  in  NREQ*32  CRC_GPOLY value per requester
req_seed  in  NREQ*32  seed value per requester
req_len  in  NREQ*CNT_W  data word count per requester
dat_valid  in  NREQ  data word valid
dat_word  in  NREQ*32  data word
dat_ready  out  NREQ  word accepted this cycle (one-hot, granted requester only)
gnt  out  NREQ  one-hot grant, held for the whole job
done  out  NREQ  one-cycle completion pulse to the granted requester
result  out  32  checksum, valid in the done cycle, held until the next done
err  out  1  abort flag, valid with done
sel  out  1  CRC bus select
rw  out  1  1 = write, 0 = read
addr  out  32  CRC bus address
data_wr  out  32  CRC bus write data
data_rd  in  32  CRC bus read data (combinational from CRC)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state IDLE; rr pointer 0.
  - gnt, done, dat_ready, sel, rw, err all 0; addr, data_wr, result all 0.
  - Reset mid-job aborts the job silently: no done pulse.
- States: IDLE, CFG_CTRL, CFG_POLY, CFG_SEED, CFG_RUN, DATA, READ, FIN.
- Bus: each access is exactly one clk cycle with sel=1. In every cycle not listed below, sel=0.
- IDLE:
  - If any req bit is set, pick the first set bit at or after rr (wrapping modulo NREQ).
  - Latch that requester's ctrl/poly/seed/len into job registers. Set gnt one-hot and rr = winner+1 (mod NREQ). Next state CFG_CTRL.
  - Otherwise stay in IDLE.
  - Arbitration happens only in IDLE. req is not re-sampled during a job; dropping req mid-job has no effect.
- CFG_CTRL: write addr=BASE+8, data_wr = ctrl | (1<<25) (WAS forced to 1).
- CFG_POLY: write addr=BASE+4, data_wr = poly.
- CFG_SEED: write addr=BASE, data_wr = seed.
- CFG_RUN: write addr=BASE+8, data_wr = ctrl & ~(1<<25) (WAS forced to 0). Next state:
  - DATA if len != 0,
  - READ if len == 0.
- DATA: dat_ready[g] = 1 combinationally while in DATA.
  - Cycle with dat_valid[g]=1: write addr=BASE, data_wr = dat_word[g]; decrement the remaining count. When the count reaches 0, go to READ.
  - Cycle with dat_valid[g]=0: sel=0, no decrement (stall).
- READ: sel=1, rw=0, addr=BASE. Capture data_rd into result at the clock edge ending the cycle.
- FIN: done[g]=1 for one cycle, err=0. gnt clears at the end of FIN. Return to IDLE; a new grant is possible on the next cycle.
- Job latency with len=0 and no stalls: grant edge to done = 6 cycles (5 bus cycles + FIN). Each data word adds 1 cycle plus stall cycles.
- Back-to-back: with all req held, grants rotate 0,1,2,3,0…; no requester is granted twice while another is waiting.
- Outputs sel/rw/addr/data_wr are combinational from state plus job registers. dat_ready is combinational from state.

Optional Feature:
- Macro: CRC_SCHED_TIMEOUT_EN.
- When defined:
  - A 16-bit stall counter clears on every accepted word and on DATA entry, and increments each DATA cycle with dat_valid[g]=0.
  - At 1000 stall cycles, go to FIN with err=1 and result=0; the CRC is not read.
- When undefined: DATA stalls indefinitely; err is tied to 0.

Test Plan:
- Reset, then req=4'b0001, ctrl=32'h0100_0000, poly=32'h04C1_1DB7, seed=32'h1234_5678, len=0:
  - bus shows writes (BASE+8, 32'h0300_0000), (BASE+4, 32'h04C1_1DB7), (BASE, 32'h1234_5678), (BASE+8, 32'h0100_0000), then one read of BASE;
  - done[0] 6 cycles after grant; result = 32'h1234_5678.
- All four req held, len=0 each: grant order 0,1,2,3,0; each done is 6 cycles after its grant; gnt is always one-hot or zero.
- Requester 2 with len=3, dat_valid low for 2 cycles before word 2: exactly 3 data writes to BASE, in order; sel=0 during the stall cycles; done 11 cycles after grant.
- rst_n asserted low during DATA: sel, gnt, dat_ready are 0 immediately (asynchronously); no done pulse; after release the next job starts from arbitration with rr=0.
- req[1] dropped during CFG_POLY: the job completes normally and done[1] pulses.
- With CRC_SCHED_TIMEOUT_EN defined: len=1, dat_valid never asserted → done pulses with err=1 and result=0 exactly 1000 stall cycles after DATA entry.
